rst_ctrl_mc: RTL



---
 rtl/rst_ctrl_pkg.sv | 28 ++
 rtl/rst_ctrl_regs.sv | 100 ++++++++++
 rtl/rst_ctrl_mc.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rst_ctrl_pkg.sv
// rtl/rst_ctrl_pkg.sv - shared constants, FSM encoding and RRS bit helpers for rst_ctrl_mc
package rst_ctrl_pkg;

  // APB byte offsets
  localparam logic [7:0] ADDR_SRW     = 8'h00;
  localparam logic [7:0] ADDR_RRS     = 8'h04;
  localparam logic [7:0] ADDR_MASK    = 8'h08;
  localparam logic [7:0] ADDR_STRETCH = 8'h0C;
  localparam logic [7:0] ADDR_LOCK    = 8'h10;

  localparam logic [31:0] SRW_KEY_DEF = 32'h20190114;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_STRETCH = 2'd2
  } state_t;

  // RRS layout: [n-1:0] sources, [n] software, [n+1] POR
  function automatic int rrs_sw_idx(input int num_src);
    return num_src;
  endfunction

  function automatic int rrs_por_idx(input int num_src);
    return num_src + 1;
  endfunction

endpackage

// File: rtl/rst_ctrl_regs.sv
// rtl/rst_ctrl_regs.sv - APB decode, MASK/STRETCH/LOCK/RRS storage and read mux
//
// Ports: pclk/prst_n clock and POR; psel/penable/pwrite/paddr/pwdata/prdata APB slave;
//   sw_key_wr pulses on a key write to SRW; rrs_load replaces RRS with rrs_val,
//   rrs_set ORs rrs_val into RRS; mask/stretch are the current register values.
// Optional: RST_CTRL_LOCK_EN adds the LOCK register at 0x10.
module rst_ctrl_regs
  import rst_ctrl_pkg::*;
#(
  parameter int          NUM_SRC     = 4,
  parameter int          STRETCH_W   = 8,
  parameter int          STRETCH_DEF = 16,
  parameter logic [31:0] SRW_KEY     = SRW_KEY_DEF
) (
  input  logic                 pclk,
  input  logic                 prst_n,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [7:0]           paddr,
  input  logic [31:0]          pwdata,
  output logic [31:0]          prdata,
  output logic                 sw_key_wr,
  input  logic                 rrs_load,
  input  logic                 rrs_set,
  input  logic [NUM_SRC+1:0]   rrs_val,
  output logic [NUM_SRC-1:0]   mask,
  output logic [STRETCH_W-1:0] stretch
);

  localparam int RW = NUM_SRC + 2;
  localparam logic [STRETCH_W-1:0] STRETCH_RST = STRETCH_W'(STRETCH_DEF);
  localparam logic [RW-1:0] RRS_RST = RW'(1) << rrs_por_idx(NUM_SRC);

  logic           wr, rd, locked;
  logic [RW-1:0]  rrs_q, rrs_d, w1c;
  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic [STRETCH_W-1:0] stretch_q, stretch_d;

  assign wr = psel & penable & pwrite;
  assign rd = psel & penable & ~pwrite;

  assign sw_key_wr = wr && (paddr == ADDR_SRW) && (pwdata == SRW_KEY);
  assign w1c = (wr && (paddr == ADDR_RRS)) ? pwdata[RW-1:0] : '0;

`ifdef RST_CTRL_LOCK_EN
  logic lock_q, lock_d;
  assign lock_d = lock_q | (wr && (paddr == ADDR_LOCK) && pwdata[0]);
  assign locked = lock_q;
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) lock_q <= 1'b0;
    else         lock_q <= lock_d;
  end
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    // A cause recorded this cycle beats a simultaneous W1C of the same bit
    rrs_d = (rrs_q & ~w1c) | (rrs_set ? rrs_val : '0);
    if (rrs_load) rrs_d = rrs_val;

    mask_d = mask_q;
    if (wr && (paddr == ADDR_MASK) && !locked) mask_d = pwdata[NUM_SRC-1:0];

    stretch_d = stretch_q;
    if (wr && (paddr == ADDR_STRETCH) && !locked) stretch_d = pwdata[STRETCH_W-1:0];
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      rrs_q     <= RRS_RST;
      mask_q    <= '1;
      stretch_q <= STRETCH_RST;
    end else begin
      rrs_q     <= rrs_d;
      mask_q    <= mask_d;
      stretch_q <= stretch_d;
    end
  end

  always_comb begin
    prdata = '0;
    if (rd) begin
      case (paddr)
        ADDR_RRS:     prdata[RW-1:0]        = rrs_q;
        ADDR_MASK:    prdata[NUM_SRC-1:0]   = mask_q;
        ADDR_STRETCH: prdata[STRETCH_W-1:0] = stretch_q;
`ifdef RST_CTRL_LOCK_EN
        ADDR_LOCK:    prdata[0]             = lock_q;
`endif
        default:      prdata = '0;
      endcase
    end
  end

  assign mask    = mask_q;
  assign stretch = stretch_q;

endmodule

// File: rtl/rst_ctrl_mc.sv
// rtl/rst_ctrl_mc.sv - multi-source reset controller with keyed software reset and release stretch
//
// Ports: pclk clock; prst_n POR (async assert, active-low); psel/penable/pwrite/paddr/
//   pwdata/prdata/pready APB slave (pready tied 1); rst_src_n active-low requests already
//   synchronised to pclk; sys_rst_n registered active-low system reset.
// Optional: RST_CTRL_LOCK_EN adds the LOCK register (0x10) freezing MASK/STRETCH.
module rst_ctrl_mc
  import rst_ctrl_pkg::*;
#(
  parameter int          NUM_SRC     = 4,
  parameter int          STRETCH_W   = 8,
  parameter int          STRETCH_DEF = 16,
  parameter logic [31:0] SRW_KEY     = SRW_KEY_DEF
) (
  input  logic               pclk,
  input  logic               prst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [7:0]         paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  input  logic [NUM_SRC-1:0] rst_src_n,
  output logic               sys_rst_n
);

  localparam int RW     = NUM_SRC + 2;
  localparam int SW_IDX = rrs_sw_idx(NUM_SRC);

  logic [NUM_SRC-1:0]   mask, act_vec;
  logic [STRETCH_W-1:0] stretch, stretch_load;
  logic                 act, sw_key_wr, sw_req;
  logic                 rrs_load, rrs_set;
  logic [RW-1:0]        rrs_val;

  state_t               state_q, state_d;
  logic [STRETCH_W-1:0] cnt_q, cnt_d;
  logic                 por_pend_q, por_pend_d;
  logic                 sys_rst_n_q, sys_rst_n_d;

  rst_ctrl_regs #(
    .NUM_SRC    (NUM_SRC),
    .STRETCH_W  (STRETCH_W),
    .STRETCH_DEF(STRETCH_DEF),
    .SRW_KEY    (SRW_KEY)
  ) u_regs (
    .pclk     (pclk),
    .prst_n   (prst_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .sw_key_wr(sw_key_wr),
    .rrs_load (rrs_load),
    .rrs_set  (rrs_set),
    .rrs_val  (rrs_val),
    .mask     (mask),
    .stretch  (stretch)
  );

  assign pready       = 1'b1;
  assign act_vec      = ~rst_src_n & mask;
  assign act          = |act_vec;
  assign sw_req       = sw_key_wr && (state_q == ST_IDLE);
  assign stretch_load = (stretch == '0) ? STRETCH_W'(1) : stretch;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    por_pend_d = por_pend_q;
    rrs_load   = 1'b0;
    rrs_set    = 1'b0;
    rrs_val    = '0;
    case (state_q)
      ST_IDLE: begin
        if (act) begin
          state_d              = ST_ASSERT;
          rrs_load             = 1'b1;
          rrs_val[NUM_SRC-1:0] = act_vec;
          por_pend_d           = 1'b0;
        end else if (sw_req) begin
          state_d         = ST_STRETCH;
          cnt_d           = stretch_load;
          rrs_load        = 1'b1;
          rrs_val[SW_IDX] = 1'b1;
          por_pend_d      = 1'b0;
        end else if (por_pend_q) begin
          // First cycle after POR: hold the system in reset for a full stretch;
          // RRS already holds the POR cause from its reset value.
          state_d    = ST_STRETCH;
          cnt_d      = stretch_load;
          por_pend_d = 1'b0;
        end
      end
      ST_ASSERT: begin
        rrs_set              = 1'b1;
        rrs_val[NUM_SRC-1:0] = act_vec;
        if (!act) begin
          state_d = ST_STRETCH;
          cnt_d   = stretch_load;
        end
      end
      ST_STRETCH: begin
        if (act) begin
          state_d              = ST_ASSERT;
          rrs_set              = 1'b1;
          rrs_val[NUM_SRC-1:0] = act_vec;
        end else if (cnt_q <= STRETCH_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - STRETCH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered from next state so a request seen in cycle N drops reset in N+1
    sys_rst_n_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      por_pend_q  <= 1'b1;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      por_pend_q  <= por_pend_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  assign sys_rst_n = sys_rst_n_q;

endmodule
